// File: rtl/sec_graph_loader_if.sv
// -----------------------------------------------------------------------------
// sec_graph_loader_if
// Host-side reload bus of the security-graph loader.
//   host_load_start  : one-cycle pulse requesting a reload (host -> loader)
//   host_load_done   : one-cycle pulse ending the reload    (host -> loader)
//   host_wr_valid    : write word presented                 (host -> loader)
//   host_wr_ready    : loader accepts words (LOAD only)     (loader -> host)
//   host_wr_addr     : graph word index [12:2]              (host -> loader)
//   host_wr_bblock   : basic-block word                     (host -> loader)
//   host_wr_nhop     : next-hop word                        (host -> loader)
// Modports: master = host side, slave = loader side.
// -----------------------------------------------------------------------------
interface sec_graph_loader_if;
  logic        host_load_start;
  logic        host_load_done;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [12:2] host_wr_addr;
  logic [31:0] host_wr_bblock;
  logic [31:0] host_wr_nhop;

  modport master (
    output host_load_start, host_load_done, host_wr_valid,
           host_wr_addr, host_wr_bblock, host_wr_nhop,
    input  host_wr_ready
  );

  modport slave (
    input  host_load_start, host_load_done, host_wr_valid,
           host_wr_addr, host_wr_bblock, host_wr_nhop,
    output host_wr_ready
  );
endinterface

// File: rtl/sec_graph_loader.sv
// -----------------------------------------------------------------------------
// sec_graph_loader
// Reloads the security graph (bb_ram, its duplicate and next_hop_ram) while
// holding sec_monitor in reset. Sequence: IDLE -> DRAIN -> LOAD -> FLUSH -> IDLE.
//
// Parameters:
//   DRAIN_CYCLES (1..15) : monitor reset cycles before the first write
//   FLUSH_CYCLES (1..15) : monitor reset cycles after the last write
// Optional feature macro:
//   SEC_LOADER_CHECKSUM_EN : when defined, load_checksum is the running XOR of
//                            (bblock ^ nhop) over written words; otherwise 0.
// Ports:
//   core_sp_clk, reset_n (async, active-low)
//   host            : sec_graph_loader_if.slave reload bus
//   mem_addr        : shared RAM word address [12:2]
//   bbr_we/nhr_we   : byte enables, 4'hF on a write cycle
//   bbr_wdata/nhr_wdata : RAM write data
//   mon_reset       : active-high reset to sec_monitor
//   mon_drop_packet : raw drop from sec_monitor
//   drop_packet     : drop gated to IDLE
//   loader_busy     : state != IDLE
//   load_count      : words accepted in the current/last load (sat. 2048)
//   err_overflow    : sticky, word offered with load_count at 2048
//   load_checksum   : see macro above
// -----------------------------------------------------------------------------
module sec_graph_loader #(
  parameter int DRAIN_CYCLES = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 core_sp_clk,
  input  logic                 reset_n,
  sec_graph_loader_if.slave    host,
  output logic [12:2]          mem_addr,
  output logic [3:0]           bbr_we,
  output logic [3:0]           nhr_we,
  output logic [31:0]          bbr_wdata,
  output logic [31:0]          nhr_wdata,
  output logic                 mon_reset,
  input  logic                 mon_drop_packet,
  output logic                 drop_packet,
  output logic                 loader_busy,
  output logic [11:0]          load_count,
  output logic                 err_overflow,
  output logic [31:0]          load_checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [11:0] LOAD_MAX = 12'h800;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [11:0] r_load_count;
  logic        r_err_overflow;
  logic        r_vld_p1;
  logic [12:2] r_addr_p1;
  logic [31:0] r_bblock_p1;
  logic [31:0] r_nhop_p1;

  logic w_accept;
  logic w_full;
  logic w_write;

  // A word is consumed whenever ready is high; it is only written below the cap.
  assign w_accept = (r_state == S_LOAD) && host.host_wr_valid;
  assign w_full   = (r_load_count == LOAD_MAX);
  assign w_write  = w_accept && !w_full;

  always_ff @(posedge core_sp_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_load_count   <= 12'd0;
      r_err_overflow <= 1'b0;
      r_vld_p1       <= 1'b0;
      r_addr_p1      <= '0;
      r_bblock_p1    <= 32'd0;
      r_nhop_p1      <= 32'd0;
    end else begin
      // Stage p0 -> p1: register the accepted word for a one-cycle write.
      r_vld_p1 <= w_write;
      if (w_write) begin
        r_addr_p1    <= host.host_wr_addr;
        r_bblock_p1  <= host.host_wr_bblock;
        r_nhop_p1    <= host.host_wr_nhop;
        r_load_count <= r_load_count + 12'd1;
      end
      if (w_accept && w_full) begin
        r_err_overflow <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (host.host_load_start) begin
            r_state        <= S_DRAIN;
            r_cnt          <= 4'(DRAIN_CYCLES - 1);
            r_load_count   <= 12'd0;
            r_err_overflow <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 4'd0) r_state <= S_LOAD;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_LOAD: begin
          // A word valid alongside done was already taken above.
          if (host.host_load_done) begin
            r_state <= S_FLUSH;
            r_cnt   <= 4'(FLUSH_CYCLES - 1);
          end
        end
        default: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
      endcase
    end
  end

`ifdef SEC_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge core_sp_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= 32'd0;
    end else if ((r_state == S_IDLE) && host.host_load_start) begin
      r_checksum <= 32'd0;
    end else if (w_write) begin
      r_checksum <= r_checksum ^ host.host_wr_bblock ^ host.host_wr_nhop;
    end
  end

  assign load_checksum = r_checksum;
`else
  assign load_checksum = 32'h0;
`endif

  assign host.host_wr_ready = (r_state == S_LOAD);

  assign mem_addr     = r_addr_p1;
  assign bbr_we       = {4{r_vld_p1}};
  assign nhr_we       = {4{r_vld_p1}};
  assign bbr_wdata    = r_bblock_p1;
  assign nhr_wdata    = r_nhop_p1;
  assign load_count   = r_load_count;
  assign err_overflow = r_err_overflow;
  assign loader_busy  = (r_state != S_IDLE);

  // Combinational so the monitor is held in reset during reset_n as well.
  assign mon_reset   = (r_state != S_IDLE) || !reset_n;
  assign drop_packet = (r_state == S_IDLE) ? mon_drop_packet : 1'b0;

endmodule

// File: tb/tb_sec_graph_loader.sv
// -----------------------------------------------------------------------------
// tb_sec_graph_loader
// Directed table-driven bench for sec_graph_loader (DRAIN/FLUSH = 4), plus
// hand-written sequences for overflow, done-with-valid, ignored start pulses
// and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_sec_graph_loader;

`ifdef SEC_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [12:2] mem_addr;
  logic [3:0]  bbr_we;
  logic [3:0]  nhr_we;
  logic [31:0] bbr_wdata;
  logic [31:0] nhr_wdata;
  logic        mon_reset;
  logic        mon_drop;
  logic        drop_packet;
  logic        loader_busy;
  logic [11:0] load_count;
  logic        err_overflow;
  logic [31:0] load_checksum;

  int n_cmp;
  int n_bad;

  sec_graph_loader_if u_if ();

  sec_graph_loader #(.DRAIN_CYCLES(4), .FLUSH_CYCLES(4)) u_dut (
    .core_sp_clk     (clk),
    .reset_n         (reset_n),
    .host            (u_if),
    .mem_addr        (mem_addr),
    .bbr_we          (bbr_we),
    .nhr_we          (nhr_we),
    .bbr_wdata       (bbr_wdata),
    .nhr_wdata       (nhr_wdata),
    .mon_reset       (mon_reset),
    .mon_drop_packet (mon_drop),
    .drop_packet     (drop_packet),
    .loader_busy     (loader_busy),
    .load_count      (load_count),
    .err_overflow    (err_overflow),
    .load_checksum   (load_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start, done, valid;
    logic [10:0] addr;
    logic [31:0] bb, nh;
    logic        drop;
    logic        e_ready, e_busy, e_we, e_mrst, e_drop;
    logic [10:0] e_addr;
    logic [31:0] e_bbw, e_nhw;
    logic [11:0] e_cnt;
    logic [31:0] e_csum;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic st, input logic dn, input logic vl, input logic [10:0] ad,
    input logic [31:0] b, input logic [31:0] n,
    input logic rdy, input logic bsy, input logic we, input logic mr, input logic dp,
    input logic [10:0] ea, input logic [31:0] eb, input logic [31:0] en,
    input logic [11:0] ec, input logic [31:0] ecs);
    vec_t v;
    v.start = st; v.done = dn; v.valid = vl; v.addr = ad; v.bb = b; v.nh = n;
    v.drop = 1'b1;
    v.e_ready = rdy; v.e_busy = bsy; v.e_we = we; v.e_mrst = mr; v.e_drop = dp;
    v.e_addr = ea; v.e_bbw = eb; v.e_nhw = en; v.e_cnt = ec;
    v.e_csum = CSUM_ON ? ecs : 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic dn, input logic vl,
                       input logic [10:0] ad, input logic [31:0] b, input logic [31:0] n);
    u_if.host_load_start = st;
    u_if.host_load_done  = dn;
    u_if.host_wr_valid   = vl;
    u_if.host_wr_addr    = ad;
    u_if.host_wr_bblock  = b;
    u_if.host_wr_nhop    = n;
  endtask

  // Start pulse then the four DRAIN cycles; leaves the DUT in LOAD.
  task automatic go_load(input string tag);
    drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    repeat (4) tick();
    chk({tag, " in LOAD ready"}, {31'd0, u_if.host_wr_ready}, 32'd1);
  endtask

  logic [31:0] csum_m;
  int          n_wr;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n  = 1'b0;
    mon_drop = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);

    //                st dn vl addr   bb      nh     rdy bsy we mr dp eaddr  ebb     enh    cnt    csum
    tbl[0]  = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 0, 0, 0, 1, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[1]  = mk(1, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[2]  = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[3]  = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[4]  = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[5]  = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 1, 1, 0, 1, 0, 11'd0, 32'h0,  32'h0, 12'd0, 32'h00);
    tbl[6]  = mk(0, 0, 1, 11'd0, 32'h10, 32'h1, 1, 1, 1, 1, 0, 11'd0, 32'h10, 32'h1, 12'd1, 32'h11);
    tbl[7]  = mk(0, 0, 1, 11'd1, 32'h20, 32'h2, 1, 1, 1, 1, 0, 11'd1, 32'h20, 32'h2, 12'd2, 32'h33);
    tbl[8]  = mk(0, 0, 1, 11'd2, 32'h30, 32'h3, 1, 1, 1, 1, 0, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);
    tbl[9]  = mk(0, 1, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);
    tbl[10] = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);
    tbl[11] = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);
    tbl[12] = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 1, 0, 1, 0, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);
    tbl[13] = mk(0, 0, 0, 11'd0, 32'h0,  32'h0, 0, 0, 0, 0, 1, 11'd2, 32'h30, 32'h3, 12'd3, 32'h00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst mon_reset", {31'd0, mon_reset},   32'd1);
    chk("rst busy",      {31'd0, loader_busy}, 32'd0);
    chk("rst ready",     {31'd0, u_if.host_wr_ready}, 32'd0);
    chk("rst we",        {24'd0, bbr_we, nhr_we}, 32'd0);
    chk("rst addr",      {21'd0, mem_addr},    32'd0);
    chk("rst wdata",     bbr_wdata | nhr_wdata, 32'd0);
    chk("rst count",     {20'd0, load_count},  32'd0);
    chk("rst err",       {31'd0, err_overflow}, 32'd0);
    chk("rst csum",      load_checksum,        32'd0);
    reset_n  = 1'b1;
    mon_drop = 1'b1;

    // Basic three-word load with drop held high
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].start, tbl[i].done, tbl[i].valid, tbl[i].addr, tbl[i].bb, tbl[i].nh);
      mon_drop = tbl[i].drop;
      tick();
      chk($sformatf("row%0d ready", i), {31'd0, u_if.host_wr_ready}, {31'd0, tbl[i].e_ready});
      chk($sformatf("row%0d busy", i),  {31'd0, loader_busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("row%0d bbr_we", i), {28'd0, bbr_we}, tbl[i].e_we ? 32'hF : 32'h0);
      chk($sformatf("row%0d nhr_we", i), {28'd0, nhr_we}, tbl[i].e_we ? 32'hF : 32'h0);
      chk($sformatf("row%0d mon_reset", i), {31'd0, mon_reset}, {31'd0, tbl[i].e_mrst});
      chk($sformatf("row%0d drop", i), {31'd0, drop_packet}, {31'd0, tbl[i].e_drop});
      chk($sformatf("row%0d addr", i), {21'd0, mem_addr}, {21'd0, tbl[i].e_addr});
      chk($sformatf("row%0d bbw", i), bbr_wdata, tbl[i].e_bbw);
      chk($sformatf("row%0d nhw", i), nhr_wdata, tbl[i].e_nhw);
      chk($sformatf("row%0d count", i), {20'd0, load_count}, {20'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d csum", i), load_checksum, tbl[i].e_csum);
    end
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    mon_drop = 1'b0;

    // Overflow: 2049 words offered, only 2048 written
    go_load("ovf");
    csum_m = 32'd0;
    n_wr = 0;
    for (int i = 0; i < 2049; i++) begin
      drive(1'b0, 1'b0, 1'b1, i[10:0], i, {i[23:0], 8'h5A});
      if (i < 2048) csum_m = csum_m ^ i ^ {i[23:0], 8'h5A};
      tick();
      if (bbr_we == 4'hF) n_wr++;
    end
    chk("ovf ready held", {31'd0, u_if.host_wr_ready}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    if (bbr_we == 4'hF) n_wr++;
    chk("ovf writes",  n_wr, 32'd2048);
    chk("ovf count",   {20'd0, load_count}, 32'd2048);
    chk("ovf err",     {31'd0, err_overflow}, 32'd1);
    chk("ovf csum",    load_checksum, CSUM_ON ? csum_m : 32'h0);
    drive(1'b0, 1'b1, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    repeat (4) tick();
    chk("ovf back idle", {31'd0, loader_busy}, 32'd0);
    chk("ovf err sticky", {31'd0, err_overflow}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    chk("restart err clr", {31'd0, err_overflow}, 32'd0);
    chk("restart cnt clr", {20'd0, load_count}, 32'd0);
    chk("restart csum clr", load_checksum, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    repeat (4) tick();
    chk("restart ready", {31'd0, u_if.host_wr_ready}, 32'd1);

    // Start ignored in LOAD
    drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    chk("start@load ready", {31'd0, u_if.host_wr_ready}, 32'd1);
    chk("start@load count", {20'd0, load_count}, 32'd0);

    // Valid and done together: word written, FSM to FLUSH
    drive(1'b0, 1'b1, 1'b1, 11'd5, 32'hA5, 32'h5A00);
    tick();
    chk("vd we",    {28'd0, bbr_we}, 32'hF);
    chk("vd addr",  {21'd0, mem_addr}, 32'd5);
    chk("vd ready", {31'd0, u_if.host_wr_ready}, 32'd0);
    chk("vd busy",  {31'd0, loader_busy}, 32'd1);
    chk("vd count", {20'd0, load_count}, 32'd1);
    chk("vd csum",  load_checksum, CSUM_ON ? 32'h5AA5 : 32'h0);

    // Start ignored in FLUSH: IDLE still after exactly four FLUSH cycles
    drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    chk("vd we once", {28'd0, bbr_we}, 32'h0);
    repeat (2) tick();
    chk("flush busy 4th", {31'd0, loader_busy}, 32'd1);
    tick();
    chk("flush exit idle", {31'd0, loader_busy}, 32'd0);
    chk("flush count", {20'd0, load_count}, 32'd1);
    chk("flush csum",  load_checksum, CSUM_ON ? 32'h5AA5 : 32'h0);

    // Reset dropped in the middle of LOAD
    go_load("mid");
    drive(1'b0, 1'b0, 1'b1, 11'd7, 32'h1, 32'h2);
    tick();
    chk("mid we before", {28'd0, bbr_we}, 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid rst we",   {24'd0, bbr_we, nhr_we}, 32'h0);
    chk("mid rst busy", {31'd0, loader_busy}, 32'd0);
    chk("mid rst mrst", {31'd0, mon_reset}, 32'd1);
    chk("mid rst addr", {21'd0, mem_addr}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post rst%0d we", i), {24'd0, bbr_we, nhr_we}, 32'h0);
      chk($sformatf("post rst%0d mrst", i), {31'd0, mon_reset}, 32'd0);
      chk($sformatf("post rst%0d ready", i), {31'd0, u_if.host_wr_ready}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
